// File: rtl/inst_rom_loader_if.sv
// rtl/inst_rom_loader_if.sv - fetch port and loader stream between core/boot agent and instruction ROM
// master = core + boot agent side, slave = the ROM responder
interface inst_rom_loader_if;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;

  modport master (
    output ce, addr, load_start, load_valid, load_data, load_last,
    input  inst, load_ready, load_done
  );

  modport slave (
    input  ce, addr, load_start, load_valid, load_data, load_last,
    output inst, load_ready, load_done
  );
endinterface

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM responder with run-time download stream
// Zero-latency fetch path; fetches are masked while a download is sequenced.
module inst_rom_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  inst_rom_loader_if.slave bus,
  output logic             busy,
  output logic [ADDR_W:0]  word_count
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       mem [0:DEPTH-1];
  logic              xfer;
  logic [ADDR_W-1:0] idx;
  logic              out_of_range;
  logic              unloaded;
  logic              addr_unused;

  assign xfer           = (state == ST_LOAD) && bus.load_valid;
  assign bus.load_ready = (state == ST_LOAD);
  assign bus.load_done  = (state == ST_DONE);
  assign busy           = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.load_start) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            word_count <= word_count + WC_ONE;
            // pointer saturates at the last word; a full memory ends the download
            if (ptr != PTR_MAX) ptr <= ptr + PTR_ONE;
            if (bus.load_last || (ptr == PTR_MAX)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // storage is deliberately left out of reset so contents survive a reset
  always_ff @(posedge clk) begin
    if (xfer) mem[ptr] <= bus.load_data;
  end

  assign idx          = bus.addr[ADDR_W+1:2];
  assign out_of_range = |bus.addr[31:ADDR_W+2];
  assign unloaded     = ({1'b0, idx} >= word_count);
  assign addr_unused  = ^bus.addr[1:0];

  always_comb begin
    bus.inst = NOP_WORD;
    if (rst && bus.ce && !busy && !out_of_range && !unloaded) bus.inst = mem[idx];
  end
endmodule
